// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master) and instruction memory (slave).
interface ifu_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, fetches over a req/ack bus, and steps to the decoder-selected next PC.
// Optional IFU_ALIGN_CHK_EN: a misaligned next-PC halts the unit with a sticky align error instead of truncating.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  ifu_fetch_if.master      imem,
  output logic [31:0]      o_code,
  output logic             o_code_valid,
  input  logic             i_stall,
  input  logic             i_npc_sel,
  input  logic             i_zero,
  input  logic             i_jsome,
  input  logic             i_jr,
  input  logic [31:0]      i_ra_data,
  output logic [31:0]      o_pc,
  output logic [31:0]      o_pc4,
  output logic [CNT_W-1:0] o_instr_cnt,
  output logic             o_align_err
);

`ifdef IFU_ALIGN_CHK_EN
  typedef enum logic [1:0] {ST_FETCH = 2'd0, ST_WAIT = 2'd1, ST_EXEC = 2'd2, ST_HALT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ST_FETCH = 2'd0, ST_WAIT = 2'd1, ST_EXEC = 2'd2} state_t;
`endif

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_pc;
  logic [31:0]        w_pc_nxt;
  logic [31:0]        r_code;
  logic [31:0]        w_code_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_code_valid;
  logic               r_align_err;
  logic               w_align_nxt;
  logic               r_post_rst;
  logic [31:0]        w_pc4;
  logic [31:0]        w_br_tgt;
  logic [31:0]        w_jmp_tgt;
  logic [31:0]        w_npc;

  assign w_pc4     = r_pc + 32'd4;
  assign w_br_tgt  = w_pc4 + {{14{r_code[15]}}, r_code[15:0], 2'b00};
  assign w_jmp_tgt = {w_pc4[31:28], r_code[25:0], 2'b00};

  // Next-PC select, highest priority first.
  always_comb begin
    w_npc = w_pc4;
    if (i_jr) begin
      w_npc = i_ra_data;
    end else if (i_jsome) begin
      w_npc = w_jmp_tgt;
    end else if (i_npc_sel && i_zero) begin
      w_npc = w_br_tgt;
    end else begin
      w_npc = w_pc4;
    end
  end

  // Fetch/execute sequencing. r_post_rst drops an ack that may belong to a request abandoned by reset.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_code_nxt  = r_code;
    w_cnt_nxt   = r_cnt;
    w_align_nxt = r_align_err;
    case (r_state)
      ST_FETCH: begin
        if (imem.ack && !r_post_rst) begin
          w_code_nxt  = imem.rdata;
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem.ack) begin
          w_code_nxt  = imem.rdata;
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_EXEC: begin
        if (i_stall) begin
          w_state_nxt = ST_EXEC;
        end else begin
`ifdef IFU_ALIGN_CHK_EN
          if (w_npc[1:0] != 2'b00) begin
            w_align_nxt = 1'b1;
            w_state_nxt = ST_HALT;
          end else begin
            w_pc_nxt    = w_npc;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_state_nxt = ST_FETCH;
          end
`else
          w_pc_nxt    = w_npc & 32'hFFFF_FFFC;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          w_state_nxt = ST_FETCH;
`endif
        end
      end
`ifdef IFU_ALIGN_CHK_EN
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
`endif
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  // State and datapath registers; reset overrides every other input.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC;
      r_code       <= 32'h0000_0000;
      r_cnt        <= '0;
      r_code_valid <= 1'b0;
      r_align_err  <= 1'b0;
      r_post_rst   <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_code       <= w_code_nxt;
      r_cnt        <= w_cnt_nxt;
      r_code_valid <= (w_state_nxt == ST_EXEC);
      r_align_err  <= w_align_nxt;
      r_post_rst   <= 1'b0;
    end
  end

  assign imem.req     = ((r_state == ST_FETCH) || (r_state == ST_WAIT)) && !i_rst;
  assign imem.addr    = r_pc;
  assign o_code       = r_code;
  assign o_code_valid = r_code_valid;
  assign o_pc         = r_pc;
  assign o_pc4        = w_pc4;
  assign o_instr_cnt  = r_cnt;
  assign o_align_err  = r_align_err;

endmodule
